vfpu_rst_seq: RTL and testbench



---
 rtl/vfpu_rst_seq.sv | 152 +++++++++++++++
 tb/tb_vfpu_rst_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vfpu_rst_seq.sv
//------------------------------------------------------------------------------
// Module  : vfpu_rst_seq
// Brief   : Staged active-low domain reset release followed by a run window
//           with a one-shot start handshake, soft reset and restart counter.
//           Optional run-window watchdog: define VFPU_RST_SEQ_WDOG_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vfpu_rst_seq #(
   parameter int NUM_DOM     = 4,
   parameter int HOLD_CYCLES = 10,
   parameter int STAGE_GAP   = 2,
   parameter int CNT_W       = 16,
   parameter int WDOG_CYCLES = 1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sw_rst_req,
   output logic [NUM_DOM-1:0] dom_rst_n,
   output logic               run,
   output logic               start_valid,
   input  logic               start_ready,
   input  logic               test_done,
   output logic [1:0]         seq_state,
   output logic [7:0]         rst_count
`ifdef VFPU_RST_SEQ_WDOG_EN
   ,
   output logic               wdog_to
`endif
);

   localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
   localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'(STAGE_GAP - 1);
   localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(NUM_DOM - 1);

   // Configuration guard: the shared counter must reach every terminal count.
   if ((CNT_W < $clog2(HOLD_CYCLES + 1)) || (CNT_W < $clog2(STAGE_GAP + 1)) ||
       (CNT_W < $clog2(WDOG_CYCLES + 1))) begin : g_cnt_w_check
      $error("vfpu_rst_seq: CNT_W too narrow for configured cycle counts");
   end

   typedef enum logic [1:0] {
      S_HOLD    = 2'd0,
      S_RELEASE = 2'd1,
      S_RUN     = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_idx;

`ifdef VFPU_RST_SEQ_WDOG_EN
   localparam logic [CNT_W-1:0] C_WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);
   logic [CNT_W-1:0] r_wcnt;
`endif

   assign seq_state = r_state;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_HOLD;
         r_cnt       <= '0;
         r_idx       <= '0;
         dom_rst_n   <= '0;
         run         <= 1'b0;
         start_valid <= 1'b0;
         rst_count   <= 8'd0;
`ifdef VFPU_RST_SEQ_WDOG_EN
         r_wcnt      <= '0;
         wdog_to     <= 1'b0;
`endif
      end else if (sw_rst_req && (r_state != S_HOLD)) begin
         // Soft reset outranks completion, handshake and stage progress.
         r_state     <= S_HOLD;
         r_cnt       <= '0;
         r_idx       <= '0;
         dom_rst_n   <= '0;
         run         <= 1'b0;
         start_valid <= 1'b0;
         rst_count   <= sat_inc(rst_count);
      end else begin
         case (r_state)
            S_HOLD: begin
               if (sw_rst_req) begin
                  r_cnt <= '0;
               end else if (r_cnt == C_HOLD_LAST) begin
                  r_state   <= S_RELEASE;
                  r_cnt     <= '0;
                  r_idx     <= '0;
                  dom_rst_n <= NUM_DOM'(1);
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RELEASE: begin
               if (r_idx == C_IDX_LAST) begin
                  r_state     <= S_RUN;
                  run         <= 1'b1;
                  start_valid <= 1'b1;
`ifdef VFPU_RST_SEQ_WDOG_EN
                  r_wcnt      <= '0;
`endif
               end else if (r_cnt == C_GAP_LAST) begin
                  r_cnt     <= '0;
                  r_idx     <= r_idx + 1'b1;
                  dom_rst_n <= (dom_rst_n << 1) | NUM_DOM'(1);
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RUN: begin
               if (test_done) begin
                  r_state     <= S_DONE;
                  run         <= 1'b0;
                  start_valid <= 1'b0;
`ifdef VFPU_RST_SEQ_WDOG_EN
               end else if (r_wcnt == C_WDOG_LAST) begin
                  r_state     <= S_HOLD;
                  r_cnt       <= '0;
                  r_idx       <= '0;
                  dom_rst_n   <= '0;
                  run         <= 1'b0;
                  start_valid <= 1'b0;
                  rst_count   <= sat_inc(rst_count);
                  wdog_to     <= 1'b1;
`endif
               end else begin
`ifdef VFPU_RST_SEQ_WDOG_EN
                  r_wcnt <= r_wcnt + 1'b1;
`endif
                  if (start_valid && start_ready) begin
                     start_valid <= 1'b0;
                  end
               end
            end
            default: begin
               run <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_vfpu_rst_seq.sv
//------------------------------------------------------------------------------
// Module  : tb_vfpu_rst_seq
// Brief   : Directed scoreboard bench for vfpu_rst_seq (default and 1-domain).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vfpu_rst_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst  = 1'b1;
   logic       sw   = 1'b0;
   logic       rdy  = 1'b0;
   logic       done = 1'b0;
   logic [3:0] dom;
   logic       run, sv;
   logic [1:0] st;
   logic [7:0] cnt;

   logic [0:0] dom1;
   logic       run1, sv1;
   logic [1:0] st1;
   logic [7:0] cnt1;

`ifdef VFPU_RST_SEQ_WDOG_EN
   logic       wdog0, wdog1;
   logic       done2 = 1'b0;
   logic [3:0] dom2;
   logic       run2, sv2, wdog2;
   logic [1:0] st2;
   logic [7:0] cnt2;
`endif

   vfpu_rst_seq dut (
      .clk(clk), .rst(rst), .sw_rst_req(sw), .dom_rst_n(dom), .run(run),
      .start_valid(sv), .start_ready(rdy), .test_done(done),
      .seq_state(st), .rst_count(cnt)
`ifdef VFPU_RST_SEQ_WDOG_EN
      , .wdog_to(wdog0)
`endif
   );

   vfpu_rst_seq #(.NUM_DOM(1), .HOLD_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .sw_rst_req(1'b0), .dom_rst_n(dom1), .run(run1),
      .start_valid(sv1), .start_ready(1'b0), .test_done(1'b0),
      .seq_state(st1), .rst_count(cnt1)
`ifdef VFPU_RST_SEQ_WDOG_EN
      , .wdog_to(wdog1)
`endif
   );

`ifdef VFPU_RST_SEQ_WDOG_EN
   vfpu_rst_seq #(.WDOG_CYCLES(20)) dut2 (
      .clk(clk), .rst(rst), .sw_rst_req(1'b0), .dom_rst_n(dom2), .run(run2),
      .start_valid(sv2), .start_ready(1'b0), .test_done(done2),
      .seq_state(st2), .rst_count(cnt2), .wdog_to(wdog2)
   );
`endif

   typedef struct {
      string       tag;
      int          unit;
      logic [16:0] val;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   function automatic logic [16:0] P(input logic w, input logic [3:0] d,
                                     input logic r, input logic s,
                                     input logic [1:0] stt, input logic [7:0] c);
      return {w, d, r, s, stt, c};
   endfunction

   function automatic logic [16:0] observed(input int unit);
      logic [16:0] o;
      o = '0;
      if (unit == 1) begin
         o = P(1'b0, {3'b000, dom1}, run1, sv1, st1, cnt1);
`ifdef VFPU_RST_SEQ_WDOG_EN
         o[16] = wdog1;
`endif
      end else if (unit == 0) begin
         o = P(1'b0, dom, run, sv, st, cnt);
`ifdef VFPU_RST_SEQ_WDOG_EN
         o[16] = wdog0;
      end else begin
         o = P(wdog2, dom2, run2, sv2, st2, cnt2);
`endif
      end
      return o;
   endfunction

   task automatic push(input string tag, input int unit, input logic [16:0] v);
      exp_t e;
      e.tag  = tag;
      e.unit = unit;
      e.val  = v;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_chk();
      exp_t        e;
      logic [16:0] o;
      e = q.pop_front();
      o = observed(e.unit);
      checks++;
      assert (o === e.val) else begin
         errors++;
         $error("FAIL %s: observed {wdog,dom,run,sv,state,cnt}=%h expected %h",
                e.tag, o, e.val);
      end
   endtask

   initial begin
      int exp_cnt;

      repeat (3) tick();
      push("reset", 0, P(0, 4'h0, 0, 0, 2'd0, 8'd0));
      push("reset_1dom", 1, P(0, 4'h0, 0, 0, 2'd0, 8'd0));
      tick(); pop_chk(); pop_chk();
      rst = 1'b0;

      push("hold_e1", 0, P(0, 4'h0, 0, 0, 2'd0, 8'd0));
      push("1dom_rel_e1", 1, P(0, 4'h1, 0, 0, 2'd1, 8'd0));
      tick(); pop_chk(); pop_chk();
      push("1dom_run_e2", 1, P(0, 4'h1, 1, 1, 2'd2, 8'd0));
      tick(); pop_chk();
      repeat (6) tick();
      push("hold_e9", 0, P(0, 4'h0, 0, 0, 2'd0, 8'd0));
      tick(); pop_chk();
      push("rel_e10", 0, P(0, 4'h1, 0, 0, 2'd1, 8'd0));
      tick(); pop_chk();
      push("rel_e11", 0, P(0, 4'h1, 0, 0, 2'd1, 8'd0));
      tick(); pop_chk();
      push("rel_e12", 0, P(0, 4'h3, 0, 0, 2'd1, 8'd0));
      tick(); pop_chk();
      tick();
      push("rel_e14", 0, P(0, 4'h7, 0, 0, 2'd1, 8'd0));
      tick(); pop_chk();
      tick();
      push("rel_e16", 0, P(0, 4'hF, 0, 0, 2'd1, 8'd0));
      tick(); pop_chk();
      push("run_e17", 0, P(0, 4'hF, 1, 1, 2'd2, 8'd0));
      tick(); pop_chk();
      tick();
      push("sv_hold_e19", 0, P(0, 4'hF, 1, 1, 2'd2, 8'd0));
      tick(); pop_chk();

      rdy = 1'b1;
      push("hs_e20", 0, P(0, 4'hF, 1, 0, 2'd2, 8'd0));
      tick(); pop_chk();
      for (int e = 21; e <= 30; e++) begin
         if (e == 26) rdy = 1'b0;
         push("sv_once", 0, P(0, 4'hF, 1, 0, 2'd2, 8'd0));
         tick(); pop_chk();
      end

      done = 1'b1;
      push("done", 0, P(0, 4'hF, 0, 0, 2'd3, 8'd0));
      tick(); pop_chk();
      done = 1'b0;
      repeat (8) tick();
      push("done_sticky", 0, P(0, 4'hF, 0, 0, 2'd3, 8'd0));
      tick(); pop_chk();

      sw = 1'b1;
      push("sw_from_done", 0, P(0, 4'h0, 0, 0, 2'd0, 8'd1));
      tick(); pop_chk();
      sw = 1'b0;
      repeat (15) tick();
      push("rerel_last", 0, P(0, 4'hF, 0, 0, 2'd1, 8'd1));
      tick(); pop_chk();
      push("rerun", 0, P(0, 4'hF, 1, 1, 2'd2, 8'd1));
      tick(); pop_chk();

      sw = 1'b1; done = 1'b1;
      push("sw_beats_done", 0, P(0, 4'h0, 0, 0, 2'd0, 8'd2));
      tick(); pop_chk();
      sw = 1'b0; done = 1'b0;
      push("no_done_seen", 0, P(0, 4'h0, 0, 0, 2'd0, 8'd2));
      tick(); pop_chk();

      sw = 1'b1;
      repeat (299) tick();
      push("sw_held_300", 0, P(0, 4'h0, 0, 0, 2'd0, 8'd2));
      tick(); pop_chk();
      sw = 1'b0;
      repeat (8) tick();
      push("held_delay_e9", 0, P(0, 4'h0, 0, 0, 2'd0, 8'd2));
      tick(); pop_chk();
      push("held_rel_e10", 0, P(0, 4'h1, 0, 0, 2'd1, 8'd2));
      tick(); pop_chk();

      for (int i = 0; i < 256; i++) begin
         exp_cnt = (3 + i > 255) ? 255 : 3 + i;
         sw = 1'b1;
         push("sat_count", 0, P(0, 4'h0, 0, 0, 2'd0, 8'(exp_cnt)));
         tick(); pop_chk();
         sw = 1'b0;
         repeat (10) tick();
      end

      tick();
      push("rel_0011", 0, P(0, 4'h3, 0, 0, 2'd1, 8'd255));
      tick(); pop_chk();
      rst = 1'b1;
      push("rst_mid", 0, P(0, 4'h0, 0, 0, 2'd0, 8'd0));
      push("rst_mid_1dom", 1, P(0, 4'h0, 0, 0, 2'd0, 8'd0));
      tick(); pop_chk(); pop_chk();
      rst = 1'b0;

      repeat (16) tick();
      push("run_again", 0, P(0, 4'hF, 1, 1, 2'd2, 8'd0));
      tick(); pop_chk();
      done = 1'b1;
      push("done_no_hs", 0, P(0, 4'hF, 0, 0, 2'd3, 8'd0));
      tick(); pop_chk();
      done = 1'b0;

`ifdef VFPU_RST_SEQ_WDOG_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (16) tick();
      push("wd_run_e17", 2, P(0, 4'hF, 1, 1, 2'd2, 8'd0));
      tick(); pop_chk();
      repeat (18) tick();
      push("wd_pre_to", 2, P(0, 4'hF, 1, 1, 2'd2, 8'd0));
      tick(); pop_chk();
      push("wd_timeout", 2, P(1, 4'h0, 0, 0, 2'd0, 8'd1));
      tick(); pop_chk();
      repeat (5) tick();
      push("wd_sticky", 2, P(1, 4'h0, 0, 0, 2'd0, 8'd1));
      tick(); pop_chk();

      rst = 1'b1;
      push("wd_rst", 2, P(0, 4'h0, 0, 0, 2'd0, 8'd0));
      tick(); pop_chk();
      rst = 1'b0;
      repeat (17) tick();
      repeat (19) tick();
      done2 = 1'b1;
      push("wd_done_wins", 2, P(0, 4'hF, 0, 0, 2'd3, 8'd0));
      tick(); pop_chk();
      done2 = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
